// File: rtl/cp_pkg.sv
// Shared definitions for the cyclic-prefix remover (RX) and inserter (TX).
package cp_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 13;

  typedef enum logic [1:0] {S_CFG, S_DROP, S_PASS, S_ERR} cp_state_e;

  // Callers zero-extend their LEN_W-wide fields, so any LEN_W <= 32 works.
  function automatic logic cp_cfg_legal(input logic [31:0] cp, input logic [31:0] fr);
    return (fr >= 32'd2) && (cp < fr);
  endfunction
endpackage

// File: rtl/cp_skid_buffer.sv
// Two-entry valid/ready register slice carrying {last, data}; owns the output handshake.
module cp_skid_buffer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  output logic         full,
  output logic [W-1:0] signal_out,
  output logic         last_out,
  output logic         valid_out,
  input  logic         ready_in
);
  logic [W:0] mem [2];
  logic       rd_ptr, wr_ptr;
  logic [1:0] count;
  logic       pop;

  assign pop                   = valid_out & ready_in;
  assign valid_out             = count != 2'd0;
  assign full                  = count == 2'd2;
  assign {last_out, signal_out} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_last, push_data};
  end

  // Upstream never pushes when full, so count stays in 0..2.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/cp_remove.sv
// RX cyclic-prefix remover: drops cp_length prefix samples, forwards frame_length body samples.
module cp_remove
  import cp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] signal_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [LEN_W-1:0]  cp_length,
  input  logic [LEN_W-1:0]  frame_length,
  output logic [DATA_W-1:0] signal_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              last_out,
  output logic              cp_flag,
  output logic              error,
  output logic [15:0]       sym_count
);
  cp_state_e        state, cfg_state;
  logic [LEN_W-1:0] cnt, cp_q, fr_q;
  logic             full, accept, push, body_last, cfg_ok;

  assign cfg_ok    = cp_cfg_legal(32'(cp_length), 32'(frame_length));
  assign cfg_state = !cfg_ok ? S_ERR : (cp_length == '0) ? S_PASS : S_DROP;

  // ready_out depends only on registers: prefix beats are always taken, body beats need a free slot.
  assign ready_out = (state == S_DROP) | ((state == S_PASS) & ~full);
  assign cp_flag   = state == S_DROP;
  assign error     = state == S_ERR;
  assign accept    = valid_in & ready_out;
  assign push      = accept & (state == S_PASS);
  assign body_last = cnt == fr_q - LEN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_CFG;
      cnt       <= '0;
      cp_q      <= '0;
      fr_q      <= '0;
      sym_count <= '0;
    end else begin
      case (state)
        S_CFG: begin
          cp_q  <= cp_length;
          fr_q  <= frame_length;
          cnt   <= '0;
          state <= cfg_state;
        end
        S_DROP: if (accept) begin
          if (cnt == cp_q - LEN_W'(1)) begin
            cnt   <= '0;
            state <= S_PASS;
          end else begin
            cnt <= cnt + LEN_W'(1);
          end
        end
        S_PASS: if (accept) begin
          if (body_last) begin
            // Symbol boundary: relatch config so the next symbol starts with no bubble.
            sym_count <= sym_count + 16'd1;
            cnt       <= '0;
            cp_q      <= cp_length;
            fr_q      <= frame_length;
            state     <= cfg_state;
          end else begin
            cnt <= cnt + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  cp_skid_buffer #(.W(DATA_W)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (signal_in),
    .push_last  (body_last),
    .full       (full),
    .signal_out (signal_out),
    .last_out   (last_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in)
  );
endmodule

// File: tb/tb_cp_remove.sv
// Bench for cp_remove: table-driven streams plus hand sequences, scoreboard on the output port.
module tb_cp_remove;
  localparam int DW = 32;
  localparam int LW = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] signal_in = '0;
  logic          valid_in = 1'b0;
  logic          ready_out;
  logic [LW-1:0] cp_length = '0;
  logic [LW-1:0] frame_length = '0;
  logic [DW-1:0] signal_out;
  logic          valid_out;
  logic          ready_in = 1'b1;
  logic          last_out;
  logic          cp_flag;
  logic          error;
  logic [15:0]   sym_count;

  cp_remove #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .signal_in(signal_in), .valid_in(valid_in),
    .ready_out(ready_out), .cp_length(cp_length), .frame_length(frame_length),
    .signal_out(signal_out), .valid_out(valid_out), .ready_in(ready_in),
    .last_out(last_out), .cp_flag(cp_flag), .error(error), .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [DW:0] exp_q[$];
  int m_cp, m_fr, m_pos, m_syms;
  bit m_err, stall = 0, strict = 0;

  typedef struct {int cp; int fr; int nb; bit st; int syms;} vec_t;
  vec_t tab[6];

  function automatic bit legal(input int cp, input int fr);
    return (fr >= 2) && (cp < fr);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    ready_in = stall ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: checks transfers in order and stability while stalled.
  logic [DW:0] hold;
  bit stalled = 0;
  always @(negedge clk) begin
    if (rst) stalled = 0;
    else begin
      if (stalled && valid_out) chk("stable", {last_out, signal_out}, hold);
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_out: got %0h expected none", {last_out, signal_out});
        end else chk("out", {last_out, signal_out}, exp_q.pop_front());
      end
      stalled = valid_out && !ready_in;
      hold    = {last_out, signal_out};
    end
  end

  task automatic do_reset(input int cp, input int fr);
    cp_length = LW'(cp); frame_length = LW'(fr); rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_sym_count", sym_count, 0);
    chk("rst_ready_out", ready_out, 0);
    chk("rst_error", error, 0);
    chk("rst_cp_flag", cp_flag, 0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; valid_in = 1'b0; exp_q.delete();
    m_cp = cp; m_fr = fr; m_pos = 0; m_syms = 0; m_err = !legal(cp, fr);
    @(negedge clk); chk("cfg_ready", ready_out, 0);
    @(negedge clk);
    chk("post_cfg_ready", ready_out, !m_err);
    chk("post_cfg_error", error, m_err);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    int waits = 0;
    bit ok = 0;
    signal_in = d; valid_in = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (ready_out) ok = 1; else waits++;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: ready_out low for %0d cycles, expected high", waits);
    end else begin
      if (strict) chk("no_gap", waits, 0);
      if (m_pos > 0 && m_pos < m_cp) chk("drop_ready", waits, 0);
      chk("cp_flag", cp_flag, m_pos < m_cp);
      if (m_pos >= m_cp) exp_q.push_back({m_pos == m_cp + m_fr - 1, d});
      if (m_pos == m_cp + m_fr - 1) begin
        m_pos = 0; m_syms++;
        m_cp = int'(cp_length); m_fr = int'(frame_length);
        m_err = !legal(m_cp, m_fr);
      end else m_pos++;
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    stall = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drained", exp_q.size(), 0);
    chk("idle_valid", valid_out, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    tab[0] = '{4, 16, 40, 0, 2};
    tab[1] = '{4, 16, 40, 1, 2};
    tab[2] = '{0, 8, 24, 0, 3};
    tab[3] = '{7, 8, 30, 1, 2};
    tab[4] = '{0, 2, 10, 1, 5};
    tab[5] = '{1, 2, 9, 0, 3};

    // Reset with valid_in held high: nothing accepted during reset or CFG.
    valid_in = 1'b1;
    for (int t = 0; t < 6; t++) begin
      do_reset(tab[t].cp, tab[t].fr);
      stall = tab[t].st; strict = !tab[t].st;
      for (int b = 0; b < tab[t].nb; b++) send(DW'(b));
      strict = 0;
      drain();
      chk("tab_sym_count", sym_count, tab[t].syms);
      chk("tab_error", error, 0);
    end

    // cp changes 0 -> 2 mid-symbol; only the following symbol drops 2 samples.
    do_reset(0, 8); strict = 1;
    for (int b = 0; b < 12; b++) send(DW'(b));
    cp_length = LW'(2);
    for (int b = 12; b < 26; b++) send(DW'(b));
    strict = 0;
    drain();
    chk("cpchg_sym_count", sym_count, 3);

    // Illegal configuration at reset release.
    do_reset(8, 8);
    valid_in = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("err_ready", ready_out, 0);
      chk("err_valid", valid_out, 0);
      chk("err_flag", error, 1);
    end
    valid_in = 1'b0;

    // Legal -> illegal at a symbol boundary; previous symbol still drains with last.
    do_reset(2, 8);
    for (int b = 0; b < 8; b++) send(DW'(b + 200));
    cp_length = LW'(9);
    for (int b = 8; b < 10; b++) send(DW'(b + 200));
    drain();
    @(negedge clk);
    chk("bnd_err_flag", error, 1);
    chk("bnd_err_ready", ready_out, 0);
    chk("bnd_sym_count", sym_count, 1);
    @(posedge clk); #1;

    // Reset after 10 of 16 body samples; partial symbol never appears.
    do_reset(4, 16);
    for (int b = 0; b < 14; b++) send(DW'(b + 500));
    do_reset(4, 16);
    for (int b = 0; b < 20; b++) send(DW'(b + 1000));
    drain();
    chk("rst_mid_sym_count", sym_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
